// File: rtl/alu_path_if.sv
// Operand, select, handshake and result bundle for alu_path.
// The bench drives it through master; the datapath uses slave.
interface alu_path_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] PC, ACC, SP;
  logic [WIDTH-1:0] SE, MDR, ZE, SL1;
  logic [1:0]       SrcA;
  logic [2:0]       SrcB;
  logic [2:0]       ALUOP;
  logic             start;
  logic [WIDTH-1:0] aluOut;
  logic             Zero;
  logic             Carry;
  logic             busy;
  logic             done;

  modport master (
    output PC, ACC, SP, SE, MDR, ZE, SL1, SrcA, SrcB, ALUOP, start,
    input  aluOut, Zero, Carry, busy, done
  );

  modport slave (
    input  PC, ACC, SP, SE, MDR, ZE, SL1, SrcA, SrcB, ALUOP, start,
    output aluOut, Zero, Carry, busy, done
  );
endinterface

// File: rtl/alu_path.sv
// Operand-select ALU: single-cycle ops registered on accept, MUL runs as
// an iterative shift-and-add over WIDTH cycles before the result is loaded.
module alu_path #(
  parameter int WIDTH = 16,
  parameter int INC   = 2
) (
  input  logic     CLK,
  input  logic     reset,
  alu_path_if.slave bus
);
  localparam int               SH_W  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [SH_W-1:0]  LAST  = SH_W'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nxt;
  logic             busy_c, accept, is_mul, last_iter;
  logic [WIDTH-1:0] a_sel, b_sel, res_c;
  logic             carry_c;
  logic [WIDTH:0]   sum_c, dif_c;
  logic [WIDTH-1:0] a_p0, b_p0, acc_p0, acc_nxt;
  logic [SH_W-1:0]  cnt_p0;
  logic [WIDTH-1:0] res_p1;
  logic             zero_p1, carry_p1, vld_p1;

  function automatic logic [WIDTH-1:0] slt_f(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    slt_f = (a < b) ? WIDTH'(1) : '0;
  endfunction

  always_comb begin
    case (bus.SrcA)
      2'b00:   a_sel = bus.PC;
      2'b01:   a_sel = bus.ACC;
      2'b10:   a_sel = bus.SP;
      default: a_sel = '0;
    endcase
    case (bus.SrcB)
      3'b000:  b_sel = INC_W;
      3'b001:  b_sel = bus.SE;
      3'b010:  b_sel = bus.MDR;
      3'b011:  b_sel = bus.ZE;
      3'b100:  b_sel = bus.SL1;
      default: b_sel = '0;
    endcase
  end

  // SUB carry is the no-borrow bit of A + ~B + 1
  always_comb begin
    sum_c   = {1'b0, a_sel} + {1'b0, b_sel};
    dif_c   = {1'b0, a_sel} + {1'b0, ~b_sel} + {{WIDTH{1'b0}}, 1'b1};
    res_c   = '0;
    carry_c = 1'b0;
    case (bus.ALUOP)
      3'b000:  begin res_c = sum_c[WIDTH-1:0]; carry_c = sum_c[WIDTH]; end
      3'b001:  begin res_c = dif_c[WIDTH-1:0]; carry_c = dif_c[WIDTH]; end
      3'b010:  res_c = a_sel & b_sel;
      3'b011:  res_c = a_sel | b_sel;
      3'b100:  res_c = slt_f(a_sel, b_sel);
      3'b101:  res_c = a_sel << b_sel[SH_W-1:0];
      3'b110:  res_c = a_sel >> b_sel[SH_W-1:0];
      default: res_c = '0;
    endcase
  end

  assign accept    = bus.start && !busy_c;
  assign is_mul    = (bus.ALUOP == 3'b111);
  assign last_iter = (state == MUL) && (cnt_p0 == LAST);
  assign acc_nxt   = acc_p0 + (b_p0[0] ? a_p0 : '0);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL;
      MUL:     if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == MUL);
  end

  // Stage p0: captured multiplicand/multiplier and running partial product
  always_ff @(posedge CLK) begin
    if (accept && is_mul) begin
      a_p0   <= a_sel;
      b_p0   <= b_sel;
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (state == MUL) begin
      a_p0   <= a_p0 << 1;
      b_p0   <= b_p0 >> 1;
      acc_p0 <= acc_nxt;
      cnt_p0 <= cnt_p0 + SH_W'(1);
    end
  end

  // Stage p1: architectural result registers and done strobe
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      res_p1   <= '0;
      zero_p1  <= 1'b1;
      carry_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (last_iter) begin
        res_p1   <= acc_nxt;
        zero_p1  <= (acc_nxt == '0);
        carry_p1 <= 1'b0;
        vld_p1   <= 1'b1;
      end else if (accept && !is_mul) begin
        res_p1   <= res_c;
        zero_p1  <= (res_c == '0);
        carry_p1 <= carry_c;
        vld_p1   <= 1'b1;
      end
    end
  end

  assign bus.aluOut = res_p1;
  assign bus.Zero   = zero_p1;
  assign bus.Carry  = carry_p1;
  assign bus.done   = vld_p1;
  assign bus.busy   = busy_c;
endmodule

// File: tb/tb_alu_path.sv
// Scoreboard bench for alu_path at WIDTH=16/INC=2 and WIDTH=8/INC=1.
module tb_alu_path;
  logic CLK = 1'b0;
  logic reset = 1'b1;

  alu_path_if #(.WIDTH(16)) b16 ();
  alu_path_if #(.WIDTH(8))  b8  ();

  alu_path #(.WIDTH(16), .INC(2)) dut16 (.CLK(CLK), .reset(reset), .bus(b16));
  alu_path #(.WIDTH(8),  .INC(1)) dut8  (.CLK(CLK), .reset(reset), .bus(b8));

  always #5 CLK = ~CLK;

  typedef struct {
    longint res;
    bit     zero;
    bit     carry;
    int     when;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain arithmetic on unsigned operand values of width w
  function automatic void model(input int w, input int op, input longint a, input longint b,
                                output longint res, output bit carry);
    longint m   = (64'sd1 <<< w) - 1;
    longint amt = b & longint'(w - 1);
    longint sa  = (a > (m >>> 1)) ? a - (m + 1) : a;
    longint sb  = (b > (m >>> 1)) ? b - (m + 1) : b;
    carry = 1'b0;
    case (op)
      0: begin res = (a + b) & m; carry = ((a + b) > m); end
      1: begin res = (a - b) & m; carry = (a >= b); end
      2: res = a & b;
      3: res = a | b;
      4: res = (sa < sb) ? 1 : 0;
      5: res = (a << amt) & m;
      6: res = a >> amt;
      default: res = (a * b) & m;
    endcase
  endfunction

  task automatic drive(input int d, input int sa, input int sb, input int op, input bit st,
                       input longint pc, input longint acc, input longint sp, input longint se,
                       input longint mdr, input longint ze, input longint sl1);
    if (d == 0) begin
      b16.PC = pc[15:0];  b16.ACC = acc[15:0]; b16.SP = sp[15:0];
      b16.SE = se[15:0];  b16.MDR = mdr[15:0]; b16.ZE = ze[15:0]; b16.SL1 = sl1[15:0];
      b16.SrcA = sa[1:0]; b16.SrcB = sb[2:0]; b16.ALUOP = op[2:0]; b16.start = st;
    end else begin
      b8.PC = pc[7:0];    b8.ACC = acc[7:0];   b8.SP = sp[7:0];
      b8.SE = se[7:0];    b8.MDR = mdr[7:0];   b8.ZE = ze[7:0]; b8.SL1 = sl1[7:0];
      b8.SrcA = sa[1:0];  b8.SrcB = sb[2:0];   b8.ALUOP = op[2:0]; b8.start = st;
    end
  endtask

  function automatic longint rnd();
    return longint'($urandom);
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge, or,
  // for MUL, at the negedge where done is expected.
  task automatic issue(input int d, input int op, input int sa, input int sb,
                       input longint pc, input longint acc, input longint sp, input longint se,
                       input longint mdr, input longint ze, input longint sl1);
    int     w   = (d == 0) ? 16 : 8;
    longint m   = (64'sd1 <<< w) - 1;
    longint inc = (d == 0) ? 2 : 1;
    longint a, b;
    exp_t   e;
    case (sa)
      0: a = pc & m;  1: a = acc & m;  2: a = sp & m;  default: a = 0;
    endcase
    case (sb)
      0: b = inc & m; 1: b = se & m; 2: b = mdr & m; 3: b = ze & m; 4: b = sl1 & m;
      default: b = 0;
    endcase
    model(w, op, a, b, e.res, e.carry);
    e.zero = (e.res == 0);
    e.when = cyc + 1 + ((op == 7) ? w : 0);
    if (d == 0) q16.push_back(e); else q8.push_back(e);
    drive(d, sa, sb, op, 1'b1, pc, acc, sp, se, mdr, ze, sl1);
    @(posedge CLK);
    @(negedge CLK);
    if (d == 0) b16.start = 1'b0; else b8.start = 1'b0;
    if (op == 7) begin
      for (int i = 0; i < w; i++) begin
        check((d == 0) ? "busy16_mul" : "busy8_mul", (d == 0) ? b16.busy : b8.busy, 1);
        drive(d, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
        @(negedge CLK);
      end
      if (d == 0) b16.start = 1'b0; else b8.start = 1'b0;
    end
    check((d == 0) ? "busy16_idle" : "busy8_idle", (d == 0) ? b16.busy : b8.busy, 0);
  endtask

  always @(negedge CLK) begin : mon16
    exp_t e;
    if (reset && b16.done) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL done16_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q16.pop_front();
        check("res16", longint'(b16.aluOut), e.res);
        check("zero16", longint'(b16.Zero), longint'(e.zero));
        check("carry16", longint'(b16.Carry), longint'(e.carry));
        check("when16", longint'(cyc), longint'(e.when));
      end
    end
  end

  always @(negedge CLK) begin : mon8
    exp_t e;
    if (reset && b8.done) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("res8", longint'(b8.aluOut), e.res);
        check("zero8", longint'(b8.Zero), longint'(e.zero));
        check("carry8", longint'(b8.Carry), longint'(e.carry));
        check("when8", longint'(cyc), longint'(e.when));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_out16"},   longint'(b16.aluOut), 0);
    check({tag, "_zero16"},  longint'(b16.Zero), 1);
    check({tag, "_carry16"}, longint'(b16.Carry), 0);
    check({tag, "_busy16"},  longint'(b16.busy), 0);
    check({tag, "_done16"},  longint'(b16.done), 0);
    check({tag, "_out8"},    longint'(b8.aluOut), 0);
    check({tag, "_zero8"},   longint'(b8.Zero), 1);
    check({tag, "_done8"},   longint'(b8.done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_vals("rst");
    reset = 1'b1;

    // Directed cases at WIDTH=16, first start on the first edge after release
    issue(0, 0, 0, 0, 64'h0100, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 1, 2, 0, 64'h0005, 0, 0, 64'h0005, 0, 0);
    issue(0, 1, 1, 2, 0, 64'h0003, 0, 0, 64'h0005, 0, 0);
    issue(0, 4, 1, 1, 0, 64'h8000, 0, 64'h0001, 0, 0, 0);
    issue(0, 5, 1, 4, 0, 64'h0001, 0, 0, 0, 0, 64'h0013);
    issue(0, 7, 1, 2, 0, 64'h0123, 0, 0, 64'h0010, 0, 0);
    issue(0, 0, 3, 6, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    @(negedge CLK);

    // Reset in the middle of a MUL: no done, outputs back to reset values
    drive(0, 1, 2, 7, 1'b1, 0, 64'h0123, 0, 0, 64'h0010, 0, 0);
    @(posedge CLK);
    @(negedge CLK);
    b16.start = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre_abort_busy16", longint'(b16.busy), 1);
    reset = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (2) @(negedge CLK);
    check("abort_busy16", longint'(b16.busy), 0);
    reset = 1'b1;
    issue(0, 0, 2, 1, 0, 0, 64'h1234, 64'h0F0F, 0, 0, 0);

    // Directed cases at WIDTH=8, INC=1
    issue(1, 0, 2, 0, 0, 0, 64'hFF, 0, 0, 0, 0);
    issue(1, 7, 1, 2, 0, 64'h0F, 0, 0, 64'h11, 0, 0);
    issue(1, 4, 1, 3, 0, 64'h7F, 0, 0, 0, 64'h80, 0);

    // Randomized traffic on both widths, with occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      issue(0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
            rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
      if ($urandom_range(0, 3) == 0) @(negedge CLK);
    end
    for (int i = 0; i < 40; i++) begin
      issue(1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
            rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
      if ($urandom_range(0, 3) == 0) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    check("drain16", longint'(q16.size()), 0);
    check("drain8", longint'(q8.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
